// File: rtl/apa102_frame_scheduler.sv
// rtl/apa102_frame_scheduler.sv - Double-buffered frame scheduler for the apa102 LED strip driver
//
// Purpose:
//   Holds two banks of N_PIXELS x 24-bit RGB pixels. User logic writes the
//   back bank at any time; the displayed bank is played out to the apa102
//   driver once per frame tick as SOF, N_PIXELS x PIXEL, EOF using the
//   driver's strobe/busy handshake. A requested bank swap (commit_i) is
//   applied only at a frame start, so the strip never shows a torn frame.
//
// Ports:
//   clk_12mhz        system clock
//   rst              asynchronous, active-high reset
//   enable_i         frames are started only while high
//   wr_en_i          write strobe into the back bank
//   wr_addr_i        pixel index of the write (ignored when >= N_PIXELS)
//   wr_data_i        pixel colour {R, G, B}
//   commit_i         request a bank swap at the next frame start
//   apa102_busy_i    busy from the driver
//   apa102_cmd_o     00 NONE, 01 SOF, 10 PIXEL, 11 EOF (held between strobes)
//   apa102_strobe_o  single-cycle command strobe
//   pixel_red_o      red channel for the PIXEL command
//   pixel_green_o    green channel for the PIXEL command
//   pixel_blue_o     blue channel for the PIXEL command
//   frame_active_o   high from SOF issue until EOF is accepted
//   swap_done_o      single-cycle pulse when a swap is applied
//   overrun_o        sticky: a frame tick arrived while a frame was active
//   frame_count_o    completed frames, wrapping

`timescale 1ns/1ps

module apa102_frame_scheduler #(
  parameter int N_PIXELS  = 300,
  parameter int FRAME_DIV = 200000,
  parameter int AW        = (N_PIXELS > 1) ? $clog2(N_PIXELS) : 1
) (
  input  logic          clk_12mhz,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [23:0]   wr_data_i,
  input  logic          commit_i,
  input  logic          apa102_busy_i,
  output logic [1:0]    apa102_cmd_o,
  output logic          apa102_strobe_o,
  output logic [7:0]    pixel_red_o,
  output logic [7:0]    pixel_green_o,
  output logic [7:0]    pixel_blue_o,
  output logic          frame_active_o,
  output logic          swap_done_o,
  output logic          overrun_o,
  output logic [15:0]   frame_count_o
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int MW = $clog2(2 * N_PIXELS);

  localparam logic [CW-1:0] DIV_LAST = CW'(FRAME_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(N_PIXELS - 1);
  localparam logic [MW-1:0] BANK1_BASE = MW'(N_PIXELS);

  localparam logic [1:0] CMD_SOF   = 2'b01;
  localparam logic [1:0] CMD_PIXEL = 2'b10;
  localparam logic [1:0] CMD_EOF   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_FETCH,
    S_PIXEL,
    S_EOF,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_pending_q, tick_pending_d;
  logic          swap_pending_q, swap_pending_d;
  logic          disp_bank_q, disp_bank_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          strobe_q, strobe_d;
  logic [23:0]   pixel_q, pixel_d;
  logic          frame_active_q, frame_active_d;
  logic          swap_done_q, swap_done_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          tick;
  logic          issue_ok;
  logic          wr_in_range;
  logic [MW-1:0] wr_idx;
  logic [MW-1:0] rd_idx;
  logic [23:0]   rd_data_q;

  // Both banks share one array: bank 0 at [0, N), bank 1 at [N, 2N).
  logic [23:0]   mem_q [2*N_PIXELS];

  assign tick        = (cnt_q == DIV_LAST);
  // Registered strobe in the rule forces a gap cycle after every strobe,
  // giving the driver a cycle to raise busy before we look at it again.
  assign issue_ok    = !apa102_busy_i && !strobe_q;
  assign wr_in_range = (wr_addr_i <= IDX_LAST);
  // Writes target the bank that is not displayed, using the pre-swap select.
  assign wr_idx      = (disp_bank_q ? '0 : BANK1_BASE) + MW'(wr_addr_i);
  assign rd_idx      = (disp_bank_q ? BANK1_BASE : '0) + MW'(idx_q);

  // Pixel store: not reset; read is registered and tracks idx_q every cycle,
  // so data is valid in PIXEL one cycle after FETCH and stays valid while
  // PIXEL waits on the driver.
  always_ff @(posedge clk_12mhz) begin
    if (wr_en_i && wr_in_range) begin
      mem_q[wr_idx] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_idx];
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      tick_pending_q <= 1'b0;
      swap_pending_q <= 1'b0;
      disp_bank_q    <= 1'b0;
      idx_q          <= '0;
      cmd_q          <= 2'b00;
      strobe_q       <= 1'b0;
      pixel_q        <= '0;
      frame_active_q <= 1'b0;
      swap_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tick_pending_q <= tick_pending_d;
      swap_pending_q <= swap_pending_d;
      disp_bank_q    <= disp_bank_d;
      idx_q          <= idx_d;
      cmd_q          <= cmd_d;
      strobe_q       <= strobe_d;
      pixel_q        <= pixel_d;
      frame_active_q <= frame_active_d;
      swap_done_q    <= swap_done_d;
      overrun_q      <= overrun_d;
      frame_count_q  <= frame_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = tick ? '0 : cnt_q + CW'(1);
    tick_pending_d = tick_pending_q;
    swap_pending_d = swap_pending_q;
    disp_bank_d    = disp_bank_q;
    idx_d          = idx_q;
    cmd_d          = cmd_q;
    strobe_d       = 1'b0;
    pixel_d        = pixel_q;
    frame_active_d = frame_active_q;
    swap_done_d    = 1'b0;
    overrun_d      = overrun_q | (tick & frame_active_q);
    frame_count_d  = frame_count_q;

    case (state_q)
      S_IDLE: begin
        if (tick_pending_q && enable_i) begin
          tick_pending_d = 1'b0;
          if (swap_pending_q) begin
            disp_bank_d    = ~disp_bank_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
          end
          state_d = S_SOF;
        end
      end
      S_SOF: begin
        if (issue_ok) begin
          cmd_d          = CMD_SOF;
          strobe_d       = 1'b1;
          frame_active_d = 1'b1;
          idx_d          = '0;
          state_d        = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_PIXEL;
      end
      S_PIXEL: begin
        if (issue_ok) begin
          pixel_d  = rd_data_q;
          cmd_d    = CMD_PIXEL;
          strobe_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_EOF;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_EOF: begin
        if (issue_ok) begin
          cmd_d    = CMD_EOF;
          strobe_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Waiting for the issue rule here means the driver has accepted EOF.
        if (issue_ok) begin
          frame_active_d = 1'b0;
          frame_count_d  = frame_count_q + 16'd1;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // New requests are applied after any clear above, so a tick or commit
    // landing in the consuming cycle is kept for the next frame.
    if (tick) begin
      tick_pending_d = 1'b1;
    end
    if (commit_i) begin
      swap_pending_d = 1'b1;
    end
  end

  assign apa102_cmd_o    = cmd_q;
  assign apa102_strobe_o = strobe_q;
  assign pixel_red_o     = pixel_q[23:16];
  assign pixel_green_o   = pixel_q[15:8];
  assign pixel_blue_o    = pixel_q[7:0];
  assign frame_active_o  = frame_active_q;
  assign swap_done_o     = swap_done_q;
  assign overrun_o       = overrun_q;
  assign frame_count_o   = frame_count_q;

endmodule

// File: tb/tb_apa102_frame_scheduler.sv
// tb/tb_apa102_frame_scheduler.sv - Self-checking bench for apa102_frame_scheduler

`timescale 1ns/1ps

module tb_apa102_frame_scheduler;

  localparam int N  = 5;
  localparam int FD = 200;
  localparam int AW = 3;

  logic          clk_12mhz = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic          busy = 1'b0;
  logic [1:0]    apa102_cmd;
  logic          apa102_strobe;
  logic [7:0]    pixel_red, pixel_green, pixel_blue;
  logic          frame_active, swap_done, overrun;
  logic [15:0]   frame_count;

  apa102_frame_scheduler #(.N_PIXELS(N), .FRAME_DIV(FD)) dut (
    .clk_12mhz      (clk_12mhz),
    .rst            (rst),
    .enable_i       (enable),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .commit_i       (commit),
    .apa102_busy_i  (busy),
    .apa102_cmd_o   (apa102_cmd),
    .apa102_strobe_o(apa102_strobe),
    .pixel_red_o    (pixel_red),
    .pixel_green_o  (pixel_green),
    .pixel_blue_o   (pixel_blue),
    .frame_active_o (frame_active),
    .swap_done_o    (swap_done),
    .overrun_o      (overrun),
    .frame_count_o  (frame_count)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int tests = 0;
  int fails = 0;

  // Reference model: bank contents, displayed bank, pending swap, frame count.
  logic [23:0] m_mem [2][N];
  bit          m_disp = 0;
  bit          m_pending = 0;
  bit          commit_edge = 0;
  logic [15:0] m_fc = '0;
  int          cyc = 0;

  // Frame monitor state.
  bit in_frame = 0, eof_seen = 0, prev_strobe = 0, prev_active = 0;
  int exp_idx = 0;
  int sof_count = 0, pix_count = 0, eof_count = 0, swap_count = 0, done_count = 0;
  int sof_cyc = 0, done_cyc = 0;

  // Driver stub.
  int busy_len = 10;
  int busy_cnt = 0;

  // Inputs are sampled at the active edge, exactly as the DUT sees them.
  always @(posedge clk_12mhz) begin
    if (rst) begin
      cyc = 0;
      commit_edge = 0;
    end else begin
      cyc++;
      commit_edge = commit;
      if (wr_en && int'(wr_addr) < N) m_mem[m_disp ? 0 : 1][int'(wr_addr)] = wr_data;
    end
  end

  always @(negedge clk_12mhz) begin
    if (rst) begin
      m_disp = 0; m_pending = 0; m_fc = '0;
      in_frame = 0; eof_seen = 0; exp_idx = 0;
      prev_strobe = 0; prev_active = 0;
      busy_cnt = 0; busy = 1'b0;
    end else begin
      if (swap_done) begin
        tests++;
        if (!m_pending || in_frame) begin
          fails++;
          $display("FAIL swap_unexpected: pending=%0d in_frame=%0d, required pending=1 in_frame=0", m_pending, in_frame);
        end
        m_disp = !m_disp;
        m_pending = commit_edge;
        swap_count++;
      end else if (commit_edge) begin
        m_pending = 1;
      end

      if (apa102_strobe) begin
        tests++;
        if (prev_strobe || busy) begin
          fails++;
          $display("FAIL issue_rule: prev_strobe=%0d busy=%0d, required both 0", prev_strobe, busy);
        end
        tests++;
        case (apa102_cmd)
          2'b01: begin
            if (in_frame) begin
              fails++;
              $display("FAIL double_sof: SOF inside active frame at cycle %0d, required none", cyc);
            end
            in_frame = 1; eof_seen = 0; exp_idx = 0;
            sof_count++; sof_cyc = cyc;
          end
          2'b10: begin
            if (!in_frame || exp_idx >= N) begin
              fails++;
              $display("FAIL pixel_seq: pixel index %0d in_frame=%0d, required index < %0d in frame", exp_idx, in_frame, N);
            end else if ({pixel_red, pixel_green, pixel_blue} !== m_mem[m_disp][exp_idx]) begin
              fails++;
              $display("FAIL pixel_data[%0d]: got %06h, required %06h", exp_idx,
                       {pixel_red, pixel_green, pixel_blue}, m_mem[m_disp][exp_idx]);
            end
            exp_idx++; pix_count++;
          end
          2'b11: begin
            if (!in_frame || exp_idx != N) begin
              fails++;
              $display("FAIL eof_seq: EOF after %0d pixels, required %0d", exp_idx, N);
            end
            eof_seen = 1; eof_count++;
          end
          default: begin
            fails++;
            $display("FAIL strobe_cmd: strobe with cmd=%b, required non-zero cmd", apa102_cmd);
          end
        endcase
      end

      if (prev_active && !frame_active) begin
        tests++;
        if (!eof_seen || frame_count !== m_fc + 16'd1) begin
          fails++;
          $display("FAIL frame_end: eof_seen=%0d frame_count=%0d, required eof_seen=1 frame_count=%0d",
                   eof_seen, frame_count, m_fc + 16'd1);
        end
        m_fc = m_fc + 16'd1;
        in_frame = 0;
        done_count++; done_cyc = cyc;
      end

      prev_active = frame_active;
      prev_strobe = apa102_strobe;

      if (apa102_strobe) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      busy = (busy_cnt > 0);
    end
  end

  task automatic write_px(input int a, input logic [23:0] d);
    @(negedge clk_12mhz);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    @(negedge clk_12mhz);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk_12mhz);
    commit = 1'b1;
    @(negedge clk_12mhz);
    commit = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk_12mhz);
      n++;
    end
    ok = (done_count >= target);
  endtask

  task automatic wait_phase(input int phase, output bit ok);
    int n = 0;
    do begin
      @(negedge clk_12mhz);
      n++;
    end while ((cyc % FD) != phase && n < 2 * FD);
    ok = ((cyc % FD) == phase);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk_12mhz);
    tests++; if (apa102_cmd !== 2'b00) begin fails++; $display("FAIL reset_cmd: got %b, required 00", apa102_cmd); end
    tests++; if (apa102_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b, required 0", apa102_strobe); end
    tests++; if ({pixel_red, pixel_green, pixel_blue} !== 24'h0) begin fails++; $display("FAIL reset_pixel: got %06h, required 000000", {pixel_red, pixel_green, pixel_blue}); end
    tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL reset_frame_active: got %b, required 0", frame_active); end
    tests++; if (swap_done !== 1'b0) begin fails++; $display("FAIL reset_swap_done: got %b, required 0", swap_done); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    tests++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_frame_count: got %0d, required 0", frame_count); end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [23:0] px [N];
    bit ok;
    px[0] = 24'h110000; px[1] = 24'h002200; px[2] = 24'h000033; px[3] = 24'hFFFFFF;
    px[4] = 24'($urandom);
    for (int i = 0; i < N; i++) write_px(i, px[i]);
    pulse_commit();
    enable = 1'b1;
    wait_frames(1, 3 * FD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL first_frame_timeout: frames=%0d, required 1", done_count); end
    tests++; if (swap_count != 1) begin fails++; $display("FAIL first_swap_count: got %0d, required 1", swap_count); end
    tests++; if (sof_count != 1 || eof_count != 1) begin fails++; $display("FAIL first_sof_eof: sof=%0d eof=%0d, required 1 and 1", sof_count, eof_count); end
    tests++; if (pix_count != N) begin fails++; $display("FAIL first_pixels: got %0d, required %0d", pix_count, N); end
    tests++; if (sof_cyc != FD + 2) begin fails++; $display("FAIL first_sof_time: cycle %0d, required %0d", sof_cyc, FD + 2); end
    tests++; if (frame_count !== 16'd1) begin fails++; $display("FAIL first_frame_count: got %0d, required 1", frame_count); end
  endtask

  task automatic test_out_of_range();
    int p0;
    bit ok;
    for (int i = 0; i < N; i++) write_px(i, 24'($urandom));
    for (int a = N; a < 8; a++) write_px(a, 24'($urandom));
    p0 = pix_count;
    wait_frames(2, 3 * FD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL oor_timeout: frames=%0d, required 2", done_count); end
    tests++; if (pix_count - p0 != N) begin fails++; $display("FAIL oor_pixels: got %0d, required %0d", pix_count - p0, N); end
    tests++; if (swap_count != 1) begin fails++; $display("FAIL oor_swap_count: got %0d, required 1", swap_count); end
  endtask

  task automatic test_enable_drop();
    int n = 0, s0, c0;
    bit ok;
    while (!(in_frame && exp_idx == 2) && n < 3 * FD) begin
      @(negedge clk_12mhz);
      n++;
    end
    enable = 1'b0;
    wait_frames(3, 3 * FD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_frame_finish: frames=%0d, required 3", done_count); end
    s0 = sof_count;
    repeat (2 * FD + 50) @(negedge clk_12mhz);
    wait_phase(5, ok);
    tests++; if (sof_count != s0) begin fails++; $display("FAIL drop_no_sof: sof=%0d, required %0d", sof_count, s0); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL drop_overrun: got %b, required 0", overrun); end
    enable = 1'b1;
    c0 = cyc;
    repeat (4) @(negedge clk_12mhz);
    tests++; if (sof_count != s0 + 1 || sof_cyc != c0 + 2) begin fails++; $display("FAIL enable_sof: sof=%0d at cycle %0d, required %0d at %0d", sof_count, sof_cyc, s0 + 1, c0 + 2); end
    wait_frames(4, 3 * FD, ok);
    tests++; if (frame_count !== 16'd4) begin fails++; $display("FAIL enable_frame_count: got %0d, required 4", frame_count); end
  endtask

  task automatic test_commit_same_cycle();
    int sw0;
    bit ok;
    sw0 = swap_count;
    wait_phase(150, ok);
    commit = 1'b1;
    @(negedge clk_12mhz);
    commit = 1'b0;
    wait_phase(0, ok);
    commit = 1'b1;
    @(negedge clk_12mhz);
    commit = 1'b0;
    wait_frames(6, 4 * FD, ok);
    tests++; if (!ok) begin fails++; $display("FAIL same_cycle_timeout: frames=%0d, required 6", done_count); end
    tests++; if (swap_count - sw0 != 2) begin fails++; $display("FAIL same_cycle_swaps: got %0d, required 2", swap_count - sw0); end
    tests++; if (frame_count !== 16'd6) begin fails++; $display("FAIL same_cycle_frame_count: got %0d, required 6", frame_count); end
  endtask

  task automatic test_overrun();
    int d0, s0;
    bit ok;
    busy_len = 60 + int'($urandom_range(0, 4));
    for (int f = 0; f < 3; f++) begin
      d0 = done_count;
      wait_frames(d0 + 1, 6 * FD, ok);
      s0 = sof_count;
      repeat (4) @(negedge clk_12mhz);
      tests++;
      if (!ok || sof_count != s0 + 1 || sof_cyc - done_cyc != 2) begin
        fails++;
        $display("FAIL back_to_back[%0d]: gap=%0d sofs=%0d, required gap 2 and one SOF", f, sof_cyc - done_cyc, sof_count - s0);
      end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky[%0d]: got %b, required 1", f, overrun); end
    end
    tests++; if (frame_count !== 16'd9) begin fails++; $display("FAIL overrun_frame_count: got %0d, required 9", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0, s0, d0;
    bit ok;
    busy_len = 10;
    while (!(apa102_strobe && apa102_cmd == 2'b10) && n < 6 * FD) begin
      @(negedge clk_12mhz);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    tests++; if (apa102_strobe !== 1'b0 || apa102_cmd !== 2'b00) begin fails++; $display("FAIL async_rst_cmd: strobe=%b cmd=%b, required 0 00", apa102_strobe, apa102_cmd); end
    tests++; if (frame_active !== 1'b0 || overrun !== 1'b0 || frame_count !== 16'd0) begin fails++; $display("FAIL async_rst_state: active=%b overrun=%b count=%0d, required 0 0 0", frame_active, overrun, frame_count); end
    tests++; if ({pixel_red, pixel_green, pixel_blue} !== 24'h0) begin fails++; $display("FAIL async_rst_pixel: got %06h, required 000000", {pixel_red, pixel_green, pixel_blue}); end
    repeat (2) @(negedge clk_12mhz);
    s0 = sof_count; d0 = done_count;
    rst = 1'b0;
    n = 0;
    while (sof_count == s0 && n < 2 * FD) begin
      @(negedge clk_12mhz);
      n++;
    end
    tests++; if (sof_count != s0 + 1 || sof_cyc != FD + 2) begin fails++; $display("FAIL post_rst_sof: sof at cycle %0d, required %0d", sof_cyc, FD + 2); end
    wait_frames(d0 + 1, 2 * FD, ok);
    tests++; if (!ok || frame_count !== 16'd1) begin fails++; $display("FAIL post_rst_frame: count=%0d, required 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_out_of_range();
    test_enable_drop();
    test_commit_same_cycle();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
